csr_interval_timer: RTL and testbench
=====================================

# csr_interval_timer

Programmable interval timer that consumes the CNT_L, CNT_H and STATUS_CTRL register contents of the control/status register file and turns them into a running 16-bit down-count with a timer interrupt. Sits directly downstream of the CSR file: reload value and control bits come from the CSR outputs, and a load strobe comes from the CSR write decode of CNT_H. The processor interrupt logic and debug readback consume `timer_irq`, `timer_missed` and `count_out`.

## Interface
Parameters:
- `WIDTH`, 8, CSR register width; the count is `2*WIDTH` bits.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `processor_enable`  in  1  high = processor running; low freezes counting and prescaling.
- `cnt_l_in`  in  WIDTH  reload value low byte (CNT_L contents).
- `cnt_h_in`  in  WIDTH  reload value high byte (CNT_H contents).
- `ctrl_in`  in  WIDTH  STATUS_CTRL contents: bit1 EN, bit2 AUTO, bits[5:3] PRESCALE exponent P; other bits ignored.
- `load_strobe`  in  1  one-cycle pulse, asserted the cycle after a CSR write to CNT_H; loads the reload value.
- `int_ack`  in  1  one-cycle pulse; clears `timer_irq` and `timer_missed`.
- `count_out`  out  2*WIDTH  current count.
- `timer_irq`  out  1  sticky interrupt request.
- `timer_missed`  out  1  sticky: an expiry occurred while `timer_irq` was already set.
- `state_out`  out  2  FSM state: 00 IDLE, 01 RUN, 10 EXPIRED.

## Operation
- Reload value R = {`cnt_h_in`, `cnt_l_in`}, sampled only on `load_strobe`.
- Active = `processor_enable` & EN.
- Prescaler: 7-bit counter. Each clock with Active and state RUN it increments. A tick occurs when it equals 2^P-1; the prescaler then wraps to 0. Cleared on load and whenever state is not RUN. While not Active it holds.
- FSM:
  - IDLE: count holds. `load_strobe` with R≠0 -> RUN, count<=R. `load_strobe` with R=0 -> stays IDLE, count<=0, no interrupt.
  - RUN: on tick, count decrements by 1. A tick with count==1 is an expiry: count<=R if AUTO and R≠0 (stay RUN), else count<=0 and -> EXPIRED (AUTO with R=0 also -> EXPIRED).
  - EXPIRED: count holds 0. `load_strobe` behaves as in IDLE.
  - EN=0 or `processor_enable`=0 in RUN: count and prescaler freeze. The state stays RUN and resumes when Active.
- `load_strobe` in any state overrides a same-cycle tick or expiry: the tick is discarded, the load is applied and no interrupt is raised.
- Interrupt: an expiry sets `timer_irq`. If `timer_irq` is already set, the expiry also sets `timer_missed`. `int_ack` clears both. Expiry in the same cycle as `int_ack` takes priority: `timer_irq`=1 and `timer_missed`=0.
- AUTO is sampled at the expiry edge. EN and P are sampled every cycle; changing P mid-count takes effect immediately against the current prescaler value. If the prescaler is above the new 2^P-1, it counts up to 127, wraps to 0, and no tick is produced on the wrap.
- Arithmetic: unsigned, modulo 2^(2*WIDTH). The count never decrements below 0.

## Timing
- Reset (`rst`=0, asynchronous): `count_out`=0, `timer_irq`=0, `timer_missed`=0, `state_out`=IDLE, prescaler=0. Reset asserted mid-count aborts the count immediately, with no interrupt.
- `load_strobe` sampled at edge N: `count_out`=R and `state_out`=RUN after edge N.
- With Active held continuously, ticks occur at edges N+k·2^P. Expiry occurs at edge N+R·2^P, and `timer_irq` is high after that edge (latency R·2^P cycles).
- AUTO period: exactly R·2^P cycles between successive expiries.
- Cycles with Active=0 extend the timeline one-for-one.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset mid-RUN with count=0x0040 -> all outputs 0 and `state_out`=00 asynchronously, with no `timer_irq`.
- EN=1, AUTO=0, P=0, load R=0x0005 at edge N -> `count_out` 5,4,3,2,1 then 0 at N+5. `timer_irq`=1 from N+5, `state_out`=10, count holds 0.
- EN=1, AUTO=1, P=2, R=0x0003 -> expiries at N+12, N+24, N+36. No `int_ack` issued -> `timer_missed`=1 after N+24. `int_ack` then clears both flags.
- Running R=0x0004 with P=0: drop `processor_enable` for 3 cycles after edge N+1 -> expiry delayed to N+7. Load R=0 -> IDLE, `count_out`=0, no interrupt.
- `int_ack` on the same edge as an expiry -> `timer_irq` stays 1, `timer_missed`=0. `load_strobe` (R=0x0010) on the expiry edge -> count=0x0010, no interrupt.
- WIDTH=8, R=0xFFFF, P=0 -> first tick gives 0xFFFE. Expiry at N+65535 with no wrap-around below 0.

Source files
------------

// File: rtl/csr_interval_timer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// csr_interval_timer
//
// Programmable interval timer. It runs behind the CSR file: the reload value
// comes from CNT_H/CNT_L, the control bits from STATUS_CTRL, and a load strobe
// from the CSR write decode of CNT_H. It produces a 2*WIDTH-bit down-count, a
// sticky timer interrupt and a sticky "missed interrupt" flag.
//
// Parameters
//   WIDTH             CSR register width. The count is 2*WIDTH bits.
//                     WIDTH must be at least 6 so that STATUS_CTRL can hold
//                     the PRESCALE field in bits [5:3].
//
// Ports
//   clk               single clock
//   rst               asynchronous, active-low reset
//   processor_enable  high = processor running; low freezes count and prescaler
//   cnt_l_in          reload value, low byte (CNT_L contents)
//   cnt_h_in          reload value, high byte (CNT_H contents)
//   ctrl_in           STATUS_CTRL: [1] EN, [2] AUTO, [5:3] PRESCALE exponent P
//   load_strobe       one-cycle pulse; samples {cnt_h_in, cnt_l_in} as reload
//   int_ack           one-cycle pulse; clears timer_irq and timer_missed
//   count_out         current count (registered)
//   timer_irq         sticky interrupt request (registered)
//   timer_missed      sticky: expiry while timer_irq already set (registered)
//   state_out         FSM state: 00 IDLE, 01 RUN, 10 EXPIRED (registered)
//
// Strobe semantics: load_strobe and int_ack carry no handshake. Each is acted
// on at every rising clock edge where it is high; a pulse held for several
// cycles is treated as that many back-to-back requests. load_strobe wins over
// any tick or expiry on the same edge, and an expiry wins over int_ack on the
// same edge.
// -----------------------------------------------------------------------------
module csr_interval_timer #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               processor_enable,
  input  logic [WIDTH-1:0]   cnt_l_in,
  input  logic [WIDTH-1:0]   cnt_h_in,
  input  logic [WIDTH-1:0]   ctrl_in,
  input  logic               load_strobe,
  input  logic               int_ack,
  output logic [2*WIDTH-1:0] count_out,
  output logic               timer_irq,
  output logic               timer_missed,
  output logic [1:0]         state_out
);

  localparam int CW = 2 * WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_EXPIRED = 2'b10
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t          state_q,  state_d;
  logic [CW-1:0]   count_q,  count_d;
  logic [CW-1:0]   reload_q, reload_d;
  logic [6:0]      presc_q,  presc_d;
  logic            irq_q,    irq_d;
  logic            missed_q, missed_d;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  logic            en_bit;
  logic            auto_bit;
  logic [2:0]      presc_exp;
  logic [6:0]      presc_mask;
  logic            active;
  logic            running;
  logic            tick;
  logic            cnt_is_one;
  logic            cnt_is_zero;
  logic            expiry;
  logic            auto_reload;
  logic [CW-1:0]   reload_value;
  logic            reload_nz;
  logic            unused_ctrl_bits;

  assign en_bit    = ctrl_in[1];
  assign auto_bit  = ctrl_in[2];
  assign presc_exp = ctrl_in[5:3];

  // Bits of STATUS_CTRL that this block does not interpret.
  assign unused_ctrl_bits = ^{ctrl_in[WIDTH-1:6], ctrl_in[0]};

  // Terminal prescaler value 2^P-1, built by shifting an all-ones pattern so
  // P=0 gives 0 (tick every active cycle) and P=7 gives 127.
  assign presc_mask = 7'h7F >> (3'd7 - presc_exp);

  assign active  = processor_enable & en_bit;
  assign running = (state_q == ST_RUN);

  // P is sampled live. If it shrinks below the current prescaler value the
  // compare simply never matches until the 7-bit counter wraps through 0,
  // which is the intended "count up to 127, wrap, no tick" behaviour.
  assign tick = running & active & (presc_q == presc_mask);

  assign cnt_is_one  = (count_q == CW'(1));
  assign cnt_is_zero = (count_q == '0);

  assign reload_value = {cnt_h_in, cnt_l_in};
  assign reload_nz    = |reload_value;

  // A load on the same edge discards the tick, so no expiry is reported.
  assign expiry = tick & cnt_is_one & ~load_strobe;

  // AUTO is sampled on the expiry edge; a stored reload of 0 cannot restart.
  assign auto_reload = expiry & auto_bit & (|reload_q);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (load_strobe) begin
      // Load behaves identically from every state.
      state_d = reload_nz ? ST_RUN : ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_RUN: begin
          if (expiry && !auto_reload) begin
            state_d = ST_EXPIRED;
          end
        end
        ST_EXPIRED: begin
          state_d = ST_EXPIRED;
        end
        default: begin
          // Unreachable encoding: fall back to a safe idle state.
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (all driven straight from registers)
  // ---------------------------------------------------------------------------
  always_comb begin
    state_out    = state_q;
    count_out    = count_q;
    timer_irq    = irq_q;
    timer_missed = missed_q;
  end

  // ---------------------------------------------------------------------------
  // Count, prescaler and reload datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d  = count_q;
    presc_d  = presc_q;
    reload_d = reload_q;

    if (load_strobe) begin
      reload_d = reload_value;
      count_d  = reload_value;
      presc_d  = '0;
    end else if (!running) begin
      // IDLE / EXPIRED: count holds, prescaler parked at 0 so a later load
      // always starts a full prescale period.
      presc_d = '0;
    end else if (active) begin
      if (tick) begin
        presc_d = '0;
        if (cnt_is_one) begin
          count_d = auto_reload ? reload_q : '0;
        end else if (!cnt_is_zero) begin
          // Guard keeps the count from ever wrapping below zero.
          count_d = count_q - CW'(1);
        end
      end else begin
        presc_d = presc_q + 7'd1;
      end
    end
    // RUN but not active: everything holds.
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= '0;
      presc_q  <= '0;
      reload_q <= '0;
    end else begin
      count_q  <= count_d;
      presc_q  <= presc_d;
      reload_q <= reload_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt flags
  // ---------------------------------------------------------------------------
  always_comb begin
    irq_d    = irq_q;
    missed_d = missed_q;
    if (expiry) begin
      // Expiry beats a same-edge acknowledge: the ack consumes the previous
      // interrupt, so nothing was missed.
      irq_d    = 1'b1;
      missed_d = int_ack ? 1'b0 : (missed_q | irq_q);
    end else if (int_ack) begin
      irq_d    = 1'b0;
      missed_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_q    <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      irq_q    <= irq_d;
      missed_q <= missed_d;
    end
  end

endmodule

// File: tb/tb_csr_interval_timer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_csr_interval_timer
//
// Directed bench for csr_interval_timer (WIDTH=8). Every output change is an
// event: the stimulus side pushes the expected (edge number, snapshot) of each
// change into exp_q before it drives the vector; the monitor watches the DUT
// on falling edges and pops/compares one entry per observed change.
// -----------------------------------------------------------------------------
module tb_csr_interval_timer;

  localparam int W  = 8;
  localparam int SW = 20;        // {state[1:0], irq, missed, count[15:0]}
  localparam int EW = 32 + SW;   // {edge number, snapshot}

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_EXP  = 2'b10;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           processor_enable = 1'b0;
  logic [W-1:0]   cnt_l_in = '0;
  logic [W-1:0]   cnt_h_in = '0;
  logic [W-1:0]   ctrl_in  = '0;
  logic           load_strobe = 1'b0;
  logic           int_ack = 1'b0;
  logic [2*W-1:0] count_out;
  logic           timer_irq;
  logic           timer_missed;
  logic [1:0]     state_out;

  logic [31:0]    cyc = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  csr_interval_timer #(.WIDTH(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .processor_enable (processor_enable),
    .cnt_l_in         (cnt_l_in),
    .cnt_h_in         (cnt_h_in),
    .ctrl_in          (ctrl_in),
    .load_strobe      (load_strobe),
    .int_ack          (int_ack),
    .count_out        (count_out),
    .timer_irq        (timer_irq),
    .timer_missed     (timer_missed),
    .state_out        (state_out)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [EW-1:0] exp_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;

  logic [1:0]    e_st   = S_IDLE;
  logic          e_irq  = 1'b0;
  logic          e_miss = 1'b0;
  logic [15:0]   e_cnt  = '0;
  logic [SW-1:0] last_pushed = '0;

  // Push the tracked expected snapshot for edge c, if it is a change.
  function automatic void emit(input logic [31:0] c);
    logic [SW-1:0] s;
    s = {e_st, e_irq, e_miss, e_cnt};
    if (s != last_pushed) begin
      exp_q.push_back({c, s});
      last_pushed = s;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  logic [SW-1:0] prev_snap = '0;
  logic [SW-1:0] cur_snap;
  logic [EW-1:0] mon_e;

  always @(negedge clk) begin
    cur_snap = {state_out, timer_irq, timer_missed, count_out};
    if (cur_snap !== prev_snap) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL mon_unexpected: cyc %0d got st=%b irq=%b miss=%b cnt=%h, want no change",
                 cyc, cur_snap[19:18], cur_snap[17], cur_snap[16], cur_snap[15:0]);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e[EW-1:SW] !== cyc || mon_e[SW-1:0] !== cur_snap) begin
          n_fail++;
          $display("FAIL mon_event: got cyc %0d st=%b irq=%b miss=%b cnt=%h, want cyc %0d st=%b irq=%b miss=%b cnt=%h",
                   cyc, cur_snap[19:18], cur_snap[17], cur_snap[16], cur_snap[15:0],
                   mon_e[EW-1:SW], mon_e[19:18], mon_e[17], mon_e[16], mon_e[15:0]);
        end
      end
      prev_snap = cur_snap;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change 1ns after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic goto(input logic [31:0] c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Load r with control word c, sampled at edge e.
  task automatic load_at(input logic [31:0] e, input logic [15:0] r, input logic [7:0] c);
    goto(e - 32'd1);
    cnt_h_in    = r[15:8];
    cnt_l_in    = r[7:0];
    ctrl_in     = c;
    load_strobe = 1'b1;
    goto(e);
    load_strobe = 1'b0;
  endtask

  task automatic ack_at(input logic [31:0] e);
    goto(e - 32'd1);
    int_ack = 1'b1;
    goto(e);
    int_ack = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation did not finish at cyc %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [31:0] n;
  logic [31:0] l;

  initial begin
    #1 rst = 1'b0;
    #1;
    check("reset_state",  {30'd0, state_out}, 32'd0);
    check("reset_count",  {16'd0, count_out}, 32'd0);
    check("reset_irq",    {31'd0, timer_irq}, 32'd0);
    check("reset_missed", {31'd0, timer_missed}, 32'd0);
    goto(3);
    rst = 1'b1;
    processor_enable = 1'b1;

    // One-shot, EN=1 AUTO=0 P=0, R=5.
    n = 32'd6;
    e_st = S_RUN; e_cnt = 16'd5; emit(n);
    for (int k = 1; k <= 4; k++) begin
      e_cnt = 16'(5 - k); emit(n + 32'(k));
    end
    e_st = S_EXP; e_cnt = 16'd0; e_irq = 1'b1; emit(n + 32'd5);
    e_irq = 1'b0; emit(n + 32'd8);
    load_at(n, 16'h0005, 8'h02);
    goto(n + 32'd6);
    check("oneshot_state", {30'd0, state_out}, {30'd0, S_EXP});
    check("oneshot_irq",   {31'd0, timer_irq}, 32'd1);
    check("oneshot_count", {16'd0, count_out}, 32'd0);
    ack_at(n + 32'd8);

    // AUTO, P=2, R=3: expiries every 12 cycles, second one unacked.
    n = 32'd20;
    e_st = S_RUN; e_cnt = 16'd3; emit(n);
    e_cnt = 16'd2; emit(n + 32'd4);
    e_cnt = 16'd1; emit(n + 32'd8);
    e_cnt = 16'd3; e_irq = 1'b1; emit(n + 32'd12);
    e_cnt = 16'd2; emit(n + 32'd16);
    e_cnt = 16'd1; emit(n + 32'd20);
    e_cnt = 16'd3; e_miss = 1'b1; emit(n + 32'd24);
    e_irq = 1'b0; e_miss = 1'b0; emit(n + 32'd26);
    e_cnt = 16'd2; emit(n + 32'd28);
    // Reload R=4, P=0 mid-count, then stall processor_enable for 3 edges.
    l = n + 32'd30;
    e_cnt = 16'd4; emit(l);
    e_cnt = 16'd3; emit(l + 32'd1);
    e_cnt = 16'd2; emit(l + 32'd5);
    e_cnt = 16'd1; emit(l + 32'd6);
    e_st = S_EXP; e_cnt = 16'd0; e_irq = 1'b1; emit(l + 32'd7);
    e_irq = 1'b0; emit(l + 32'd9);
    e_st = S_IDLE; emit(l + 32'd11);

    load_at(n, 16'h0003, 8'h16);
    goto(n + 32'd25);
    check("auto_missed", {31'd0, timer_missed}, 32'd1);
    ack_at(n + 32'd26);
    load_at(l, 16'h0004, 8'h02);
    goto(l + 32'd1);
    processor_enable = 1'b0;
    goto(l + 32'd4);
    processor_enable = 1'b1;
    ack_at(l + 32'd9);
    load_at(l + 32'd11, 16'h0000, 8'h02);
    goto(l + 32'd12);
    check("load_zero_state", {30'd0, state_out}, {30'd0, S_IDLE});
    check("load_zero_irq",   {31'd0, timer_irq}, 32'd0);

    // AUTO P=0 R=2: ack coincident with expiry, load coincident with expiry.
    n = l + 32'd14;
    e_st = S_RUN; e_cnt = 16'd2; emit(n);
    e_cnt = 16'd1; emit(n + 32'd1);
    e_cnt = 16'd2; e_irq = 1'b1; emit(n + 32'd2);
    e_cnt = 16'd1; emit(n + 32'd3);
    e_cnt = 16'd2; emit(n + 32'd4);
    e_cnt = 16'd1; emit(n + 32'd5);
    e_cnt = 16'h0010; emit(n + 32'd6);
    e_cnt = 16'h000F; e_irq = 1'b0; emit(n + 32'd7);
    e_st = S_IDLE; e_cnt = 16'd0; emit(n + 32'd8);

    load_at(n, 16'h0002, 8'h06);
    goto(n + 32'd3);
    // New CSR contents must not affect the AUTO reload until a load strobe.
    cnt_h_in = 8'h00;
    cnt_l_in = 8'h10;
    ack_at(n + 32'd4);
    check("ack_vs_expiry_irq",    {31'd0, timer_irq}, 32'd1);
    check("ack_vs_expiry_missed", {31'd0, timer_missed}, 32'd0);
    load_at(n + 32'd6, 16'h0010, 8'h06);
    check("load_vs_expiry_count",  {16'd0, count_out}, 32'h10);
    check("load_vs_expiry_missed", {31'd0, timer_missed}, 32'd0);
    ack_at(n + 32'd7);
    load_at(n + 32'd8, 16'h0000, 8'h06);

    // Full-range count R=0xFFFF, P=0.
    n = n + 32'd12;
    e_st = S_RUN;
    for (int k = 0; k <= 65534; k++) begin
      e_cnt = 16'(32'hFFFF - k); emit(n + 32'(k));
    end
    e_st = S_EXP; e_cnt = 16'd0; e_irq = 1'b1; emit(n + 32'd65535);
    e_irq = 1'b0; emit(n + 32'd65538);
    load_at(n, 16'hFFFF, 8'h02);
    goto(n + 32'd1);
    check("max_first_tick", {16'd0, count_out}, 32'hFFFE);
    goto(n + 32'd65537);
    check("max_expired_count", {16'd0, count_out}, 32'd0);
    check("max_expired_irq",   {31'd0, timer_irq}, 32'd1);
    ack_at(n + 32'd65538);

    // Reset in the middle of a slow (P=7) count of 0x0040.
    l = n + 32'd65541;
    e_st = S_RUN; e_cnt = 16'h0040; emit(l);
    e_st = S_IDLE; e_cnt = 16'd0; emit(l + 32'd3);
    load_at(l, 16'h0040, 8'h3A);
    goto(l + 32'd3);
    #2 rst = 1'b0;
    #1;
    check("async_rst_state",  {30'd0, state_out}, 32'd0);
    check("async_rst_count",  {16'd0, count_out}, 32'd0);
    check("async_rst_irq",    {31'd0, timer_irq}, 32'd0);
    check("async_rst_missed", {31'd0, timer_missed}, 32'd0);
    goto(l + 32'd5);
    rst = 1'b1;
    goto(l + 32'd140);
    check("post_rst_irq", {31'd0, timer_irq}, 32'd0);

    goto(l + 32'd142);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
